// File: rtl/sync_bits_debounce_if.sv
// Bundle of the channel inputs, synchronised outputs and event handshake of
// sync_bits_debounce. The master modport is the synchroniser side.
interface sync_bits_debounce_if #(
  parameter int unsigned NCh       = 4,
  parameter int unsigned DbW       = 8,
  parameter int unsigned EdgeCntrW = 8
);
  localparam int unsigned ChW = $clog2(NCh) + 1;

  logic [NCh-1:0]           async_bits;
  logic [DbW-1:0]           db_cycles;
  logic                     cg;
  logic [NCh-1:0]           bits;
  logic [NCh-1:0]           edge_pulse;
  logic [NCh-1:0]           rise;
  logic [NCh-1:0]           fall;
  logic [NCh*EdgeCntrW-1:0] n_edge;
  logic [NCh*EdgeCntrW-1:0] n_rise;
  logic [NCh*EdgeCntrW-1:0] n_fall;
  logic                     ev_valid;
  logic [ChW-1:0]           ev_ch;
  logic                     ev_level;
  logic                     ev_ready;
  logic [NCh-1:0]           overflow;
  logic [NCh-1:0]           clr_overflow;

  modport master (
    input  async_bits, db_cycles, cg, ev_ready, clr_overflow,
    output bits, edge_pulse, rise, fall, n_edge, n_rise, n_fall,
    output ev_valid, ev_ch, ev_level, overflow
  );

  modport slave (
    output async_bits, db_cycles, cg, ev_ready, clr_overflow,
    input  bits, edge_pulse, rise, fall, n_edge, n_rise, n_fall,
    input  ev_valid, ev_ch, ev_level, overflow
  );
endinterface

// File: rtl/sync_bits_debounce.sv
// Multi-channel resynchroniser with programmable debounce, per-channel edge
// pulses and counters, and a one-slot-per-channel edge event queue.
module sync_bits_debounce #(
  parameter int unsigned NCh       = 4,
  parameter int unsigned NSync     = 2,
  parameter int unsigned DbW       = 8,
  parameter int unsigned EdgeCntrW = 8
) (
  input logic                  clk,
  input logic                  rst,
  sync_bits_debounce_if.master bus
);
  localparam int unsigned ChW = $clog2(NCh) + 1;

  typedef enum logic [0:0] {StIdle, StOffer} state_e;

  logic [NCh-1:0][NSync:0]       sync_q;
  logic [NCh-1:0][DbW-1:0]       cntr_q, cntr_d;
  logic [NCh-1:0]                deb_q, deb_d;
  logic [NCh-1:0]                stable, changed, toggle, edge_p;
  logic [NCh-1:0][EdgeCntrW-1:0] n_edge_q, n_rise_q, n_fall_q;
  logic [NCh-1:0]                pend_q, pend_d, lvl_q, lvl_d;
  logic [NCh-1:0]                fresh_q, fresh_d, ovf_q, ovf_d, acc_ch;
  state_e                        state_q, state_d;
  logic                          ev_valid_q, ev_valid_d, ev_level_q, ev_level_d;
  logic [ChW-1:0]                ev_ch_q, ev_ch_d, latch_ch;
  logic                          bypass, accept, latch;

  assign bypass = (bus.db_cycles == '0);
  assign accept = ev_valid_q && bus.ev_ready && bus.cg;

  // Resync shift register; the extra top flop holds the previous stable level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else if (bus.cg) begin
      for (int ch = 0; ch < NCh; ch++) begin
        sync_q[ch] <= {sync_q[ch][NSync-1:0], bus.async_bits[ch]};
      end
    end
  end

  // Change detection and debounce next-state per channel.
  always_comb begin
    for (int ch = 0; ch < NCh; ch++) begin
      stable[ch]  = sync_q[ch][NSync-1];
      changed[ch] = sync_q[ch][NSync] ^ stable[ch];
      toggle[ch]  = stable[ch] ^ deb_q[ch];
      if (bypass) begin
        // deb tracks the input so leaving bypass starts from a settled state
        edge_p[ch] = changed[ch];
        deb_d[ch]  = stable[ch];
        cntr_d[ch] = '0;
      end else begin
        edge_p[ch] = toggle[ch] && !changed[ch] && (cntr_q[ch] >= bus.db_cycles);
        deb_d[ch]  = edge_p[ch] ? stable[ch] : deb_q[ch];
        if (changed[ch] || !toggle[ch] || edge_p[ch]) begin
          cntr_d[ch] = '0;
        end else if (&cntr_q[ch]) begin
          cntr_d[ch] = cntr_q[ch];
        end else begin
          cntr_d[ch] = cntr_q[ch] + DbW'(1);
        end
      end
    end
  end

  // Debounce state and wrapping edge counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q    <= '0;
      cntr_q   <= '0;
      n_edge_q <= '0;
      n_rise_q <= '0;
      n_fall_q <= '0;
    end else if (bus.cg) begin
      deb_q  <= deb_d;
      cntr_q <= cntr_d;
      for (int ch = 0; ch < NCh; ch++) begin
        if (edge_p[ch]) n_edge_q[ch] <= n_edge_q[ch] + EdgeCntrW'(1);
        if (edge_p[ch] && stable[ch]) n_rise_q[ch] <= n_rise_q[ch] + EdgeCntrW'(1);
        if (edge_p[ch] && !stable[ch]) n_fall_q[ch] <= n_fall_q[ch] + EdgeCntrW'(1);
      end
    end
  end

  // Pending slots. fresh marks slot content not yet latched into an offer, so
  // an accept leaves the slot pending when a newer edge arrived during the offer.
  always_comb begin
    for (int ch = 0; ch < NCh; ch++) begin
      acc_ch[ch]  = accept && (ev_ch_q == ChW'(ch));
      pend_d[ch]  = pend_q[ch];
      lvl_d[ch]   = lvl_q[ch];
      fresh_d[ch] = fresh_q[ch];
      ovf_d[ch]   = ovf_q[ch] & ~bus.clr_overflow[ch];
      if (latch && (latch_ch == ChW'(ch))) fresh_d[ch] = 1'b0;
      if (edge_p[ch]) begin
        pend_d[ch]  = 1'b1;
        lvl_d[ch]   = stable[ch];
        fresh_d[ch] = 1'b1;
        if (pend_q[ch] && !acc_ch[ch]) ovf_d[ch] = 1'b1;
      end else if (acc_ch[ch] && !fresh_q[ch]) begin
        pend_d[ch] = 1'b0;
      end
    end
  end

  // Event FSM next-state and registered-output next values.
  always_comb begin
    state_d    = state_q;
    ev_valid_d = ev_valid_q;
    ev_ch_d    = ev_ch_q;
    ev_level_d = ev_level_q;
    latch      = 1'b0;
    latch_ch   = '0;
    unique case (state_q)
      StIdle: begin
        if (|pend_q) begin
          latch = 1'b1;
          // descending scan so the lowest pending index is the one kept
          for (int i = int'(NCh) - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
              latch_ch   = ChW'(i);
              ev_level_d = lvl_q[i];
            end
          end
          ev_ch_d    = latch_ch;
          ev_valid_d = 1'b1;
          state_d    = StOffer;
        end
      end
      StOffer: begin
        if (accept) begin
          ev_valid_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Slot, overflow and event FSM registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= '0;
      lvl_q      <= '0;
      fresh_q    <= '0;
      ovf_q      <= '0;
      state_q    <= StIdle;
      ev_valid_q <= 1'b0;
      ev_ch_q    <= '0;
      ev_level_q <= 1'b0;
    end else if (bus.cg) begin
      pend_q     <= pend_d;
      lvl_q      <= lvl_d;
      fresh_q    <= fresh_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      ev_valid_q <= ev_valid_d;
      ev_ch_q    <= ev_ch_d;
      ev_level_q <= ev_level_d;
    end
  end

  assign bus.bits       = bypass ? stable : deb_q;
  assign bus.edge_pulse = edge_p;
  assign bus.rise       = edge_p & stable;
  assign bus.fall       = edge_p & ~stable;
  assign bus.n_edge     = n_edge_q;
  assign bus.n_rise     = n_rise_q;
  assign bus.n_fall     = n_fall_q;
  assign bus.ev_valid   = ev_valid_q;
  assign bus.ev_ch      = ev_ch_q;
  assign bus.ev_level   = ev_level_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_sync_bits_debounce.sv
// Directed bench for sync_bits_debounce with an event scoreboard.
module tb_sync_bits_debounce;
  localparam int unsigned NCh       = 4;
  localparam int unsigned NSync     = 2;
  localparam int unsigned DbW       = 8;
  localparam int unsigned EdgeCntrW = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         total = 0;
  int         bad = 0;
  int         cnt;
  logic [3:0] sb[$];
  logic [3:0] want_ev;

  sync_bits_debounce_if #(.NCh(NCh), .DbW(DbW), .EdgeCntrW(EdgeCntrW)) bus ();

  sync_bits_debounce #(
    .NCh      (NCh),
    .NSync    (NSync),
    .DbW      (DbW),
    .EdgeCntrW(EdgeCntrW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic push(input int ch, input logic lvl);
    sb.push_back({ch[2:0], lvl});
  endtask

  // Scoreboard: every accepted event must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && bus.ev_valid && bus.ev_ready && bus.cg) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $error("FAIL ev_unexpected: observed=%0h expected=none", {bus.ev_ch, bus.ev_level});
      end else begin
        want_ev = sb.pop_front();
        assert ({bus.ev_ch, bus.ev_level} === want_ev) else begin
          bad++;
          $error("FAIL ev_order: observed=%0h expected=%0h", {bus.ev_ch, bus.ev_level}, want_ev);
        end
      end
    end
  end

  initial begin
    bus.async_bits   = '0;
    bus.db_cycles    = '0;
    bus.cg           = 1'b1;
    bus.ev_ready     = 1'b1;
    bus.clr_overflow = '0;
    step(3);
    chk("reset_bits", bus.bits, 0);
    chk("reset_valid", bus.ev_valid, 0);
    chk("reset_nedge", bus.n_edge, 0);
    chk("reset_ovf", bus.overflow, 0);
    rst = 1'b0;
    step(2);

    // bypass: two-cycle latency, single-cycle pulses
    bus.async_bits[0] = 1'b1;
    push(0, 1'b1);
    step(1);
    chk("t1_not_yet", bus.bits, 0);
    step(1);
    chk("t1_bits", bus.bits, 4'b0001);
    chk("t1_rise", bus.rise, 4'b0001);
    step(1);
    chk("t1_rise_width", bus.rise, 0);
    chk("t1_nrise", bus.n_rise, 8'h01);
    step(4);
    bus.async_bits[0] = 1'b0;
    push(0, 1'b0);
    step(2);
    chk("t1_fall", bus.fall, 4'b0001);
    step(1);
    chk("t1_nfall", bus.n_fall, 8'h01);
    step(4);
    chk("t1_sb_empty", sb.size(), 0);

    // debounce 4: short glitch rejected, long level gives one edge
    bus.db_cycles = 8'd4;
    bus.async_bits[1] = 1'b1;
    step(3);
    bus.async_bits[1] = 1'b0;
    cnt = 0;
    repeat (12) begin
      step(1);
      if (bus.edge_pulse[1]) cnt++;
    end
    chk("t2_glitch_edges", cnt, 0);
    chk("t2_glitch_nedge", bus.n_edge[3:2], 0);
    bus.async_bits[1] = 1'b1;
    push(1, 1'b1);
    cnt = 0;
    repeat (12) begin
      step(1);
      if (bus.rise[1]) cnt++;
    end
    chk("t2_one_rise", cnt, 1);
    chk("t2_bits", bus.bits[1], 1);
    chk("t2_nrise", bus.n_rise[3:2], 1);
    bus.async_bits[1] = 1'b0;
    push(1, 1'b0);
    step(12);
    chk("t2_bits_low", bus.bits[1], 0);
    chk("t2_nedge", bus.n_edge[3:2], 2);

    // counter wrap at 2 bits
    bus.db_cycles = '0;
    for (int k = 0; k < 5; k++) begin
      bus.async_bits[2] = 1'b1;
      push(2, 1'b1);
      step(4);
      bus.async_bits[2] = 1'b0;
      push(2, 1'b0);
      step(4);
    end
    step(2);
    chk("t3_nrise_wrap", bus.n_rise[5:4], 1);
    chk("t3_nfall_wrap", bus.n_fall[5:4], 1);
    chk("t3_nedge_wrap", bus.n_edge[5:4], 2);
    chk("t3_sb_empty", sb.size(), 0);

    // simultaneous rises: lowest channel first, two cycles apart
    bus.async_bits = 4'b1001;
    push(0, 1'b1);
    push(3, 1'b1);
    step(2);
    chk("t4_edges", bus.edge_pulse, 4'b1001);
    step(2);
    chk("t4_valid0", bus.ev_valid, 1);
    chk("t4_ch0", bus.ev_ch, 0);
    chk("t4_lvl0", bus.ev_level, 1);
    step(1);
    chk("t4_gap", bus.ev_valid, 0);
    step(1);
    chk("t4_valid3", bus.ev_valid, 1);
    chk("t4_ch3", bus.ev_ch, 3);
    step(1);
    chk("t4_done", bus.ev_valid, 0);

    // rise then fall while stalled: held offer, refilled slot, overflow
    bus.ev_ready = 1'b0;
    bus.async_bits[1] = 1'b1;
    push(1, 1'b1);
    step(3);
    bus.async_bits[1] = 1'b0;
    push(1, 1'b0);
    step(6);
    chk("t5_valid", bus.ev_valid, 1);
    chk("t5_ch", bus.ev_ch, 1);
    chk("t5_lvl_held", bus.ev_level, 1);
    chk("t5_ovf", bus.overflow, 4'b0010);
    bus.ev_ready = 1'b1;
    step(1);
    chk("t5_accepted", bus.ev_valid, 0);
    step(1);
    chk("t5_reoffer", bus.ev_valid, 1);
    chk("t5_reoffer_lvl", bus.ev_level, 0);
    step(1);
    chk("t5_drained", bus.ev_valid, 0);
    chk("t5_ovf_sticky", bus.overflow, 4'b0010);
    bus.clr_overflow = 4'b0010;
    step(1);
    bus.clr_overflow = '0;
    chk("t5_ovf_clr", bus.overflow, 0);

    // clock gate freezes an offer; async reset drops it without an edge
    bus.ev_ready = 1'b0;
    bus.async_bits[2] = 1'b1;
    push(2, 1'b1);
    step(4);
    chk("t6_offer", bus.ev_valid, 1);
    chk("t6_offer_ch", bus.ev_ch, 2);
    bus.cg = 1'b0;
    bus.ev_ready = 1'b1;
    bus.async_bits[1] = 1'b1;
    step(3);
    chk("t6_frozen_valid", bus.ev_valid, 1);
    chk("t6_frozen_ch", bus.ev_ch, 2);
    chk("t6_frozen_bits", bus.bits, 4'b1101);
    chk("t6_frozen_nrise", bus.n_rise, 8'h6A);
    chk("t6_frozen_nfall", bus.n_fall, 8'h19);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", bus.ev_valid, 0);
    chk("t6_rst_nrise", bus.n_rise, 0);
    chk("t6_rst_bits", bus.bits, 0);
    chk("t6_lost_event", sb.size(), 1);
    sb.delete();
    bus.async_bits = '0;
    bus.cg = 1'b1;
    step(2);
    rst = 1'b0;
    step(6);
    chk("t6_idle", bus.ev_valid, 0);
    chk("t6_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
